// File: rtl/timer_dev_pkg.sv
// Shared definitions for the timer device: FSM encoding,
// register word offsets, CTRL bit positions and MODE codes.
package timer_dev_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CNT  = 2'd2,
      S_INT  = 2'd3
   } state_t;

   localparam logic [29:0] OFF_CTRL   = 30'd0;
   localparam logic [29:0] OFF_PRESET = 30'd1;
   localparam logic [29:0] OFF_COUNT  = 30'd2;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_MODE = 1;
   localparam int CTRL_IM   = 3;

   localparam logic [1:0] MODE_ONESHOT  = 2'b00;
   localparam logic [1:0] MODE_PERIODIC = 2'b01;

   function automatic logic [31:0] be_merge(
      input logic [31:0] old_v,
      input logic [31:0] new_v,
      input logic [3:0]  be
   );
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
      return r;
   endfunction

endpackage

// File: rtl/tc_regfile.sv
// Register file for the timer: address decode, byte-enable
// merge for CTRL/PRESET and the combinational read mux.
module tc_regfile
   import timer_dev_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m_data_addr,
   input  logic [31:0] m_data_wdata,
   input  logic [3:0]  m_data_byteen,
   input  logic [31:0] count,
   input  logic        en_clr,
   output logic [31:0] m_data_rdata,
   output logic [3:0]  ctrl,
   output logic [31:0] preset,
   output logic        ctrl_we,
   output logic        preset_we
);

   localparam logic [29:0] BASE_W = BASE_ADDR[31:2];

   logic [29:0] word;
   logic        hit_ctrl;
   logic        hit_preset;
   logic        hit_count;
   logic        wr;
   logic [31:0] ctrl_m;
   logic [31:0] preset_m;

   assign word       = m_data_addr[31:2];
   assign hit_ctrl   = (word == BASE_W + OFF_CTRL);
   assign hit_preset = (word == BASE_W + OFF_PRESET);
   assign hit_count  = (word == BASE_W + OFF_COUNT);
   assign wr         = |m_data_byteen;
   assign ctrl_we    = wr && hit_ctrl;
   assign preset_we  = wr && hit_preset;

   assign ctrl_m   = be_merge({28'd0, ctrl}, m_data_wdata, m_data_byteen);
   assign preset_m = be_merge(preset, m_data_wdata, m_data_byteen);

   // A bus write to CTRL takes priority over the FSM clearing EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl   <= 4'd0;
         preset <= 32'd0;
      end else begin
         if (ctrl_we)
            ctrl <= ctrl_m[3:0];
         else if (en_clr)
            ctrl[CTRL_EN] <= 1'b0;
         if (preset_we)
            preset <= preset_m;
      end
   end

   always_comb begin
      m_data_rdata = 32'd0;
      unique case (1'b1)
         hit_ctrl:   m_data_rdata = {28'd0, ctrl};
         hit_preset: m_data_rdata = preset;
         hit_count:  m_data_rdata = count;
         default:    m_data_rdata = 32'd0;
      endcase
   end

endmodule

// File: rtl/timer_dev.sv
// Memory-mapped down-counting timer with one-shot and periodic
// modes and a maskable interrupt.
module timer_dev
   import timer_dev_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m_data_addr,
   input  logic [31:0] m_data_wdata,
   input  logic [3:0]  m_data_byteen,
   output logic [31:0] m_data_rdata,
   output logic        interrupt
);

   state_t      state;
   state_t      state_n;
   logic [31:0] count;
   logic [31:0] count_n;
   logic        irq_pend;
   logic        pend_n;
   logic        en_clr;
   logic [3:0]  ctrl;
   logic [31:0] preset;
   logic        ctrl_we;
   logic        preset_we;
   logic        en;
   logic [1:0]  mode;

   tc_regfile #(.BASE_ADDR(BASE_ADDR)) u_regs (
      .clk           (clk),
      .reset         (reset),
      .m_data_addr   (m_data_addr),
      .m_data_wdata  (m_data_wdata),
      .m_data_byteen (m_data_byteen),
      .count         (count),
      .en_clr        (en_clr),
      .m_data_rdata  (m_data_rdata),
      .ctrl          (ctrl),
      .preset        (preset),
      .ctrl_we       (ctrl_we),
      .preset_we     (preset_we)
   );

   assign en        = ctrl[CTRL_EN];
   assign mode      = ctrl[CTRL_MODE +: 2];
   assign interrupt = irq_pend & ctrl[CTRL_IM];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         count    <= 32'd0;
         irq_pend <= 1'b0;
      end else begin
         state    <= state_n;
         count    <= count_n;
         irq_pend <= pend_n;
      end
   end

   always_comb begin
      state_n = state;
      count_n = count;
      pend_n  = irq_pend;
      en_clr  = 1'b0;
      unique case (state)
         S_IDLE: if (en) state_n = S_LOAD;
         S_LOAD: begin
            count_n = preset;
            state_n = S_CNT;
         end
         S_CNT: begin
            if (!en)
               state_n = S_IDLE;
            else if (count > 32'd1)
               count_n = count - 32'd1;
            else begin
               count_n = 32'd0;
               pend_n  = 1'b1;
               state_n = S_INT;
            end
         end
         S_INT: begin
            if (mode == MODE_PERIODIC) begin
               pend_n  = 1'b0;
               state_n = S_LOAD;
            end else begin
               en_clr  = 1'b1;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
      // Register writes cancel this edge's FSM update
      if (ctrl_we || preset_we) begin
         state_n = S_IDLE;
         count_n = count;
         pend_n  = ctrl_we ? 1'b0 : irq_pend;
         en_clr  = 1'b0;
      end
   end

endmodule

// File: tb/tb_timer_dev.sv
// Directed self-checking bench for timer_dev.
// Edge 0 is the edge that applies the enabling CTRL write.
module tb_timer_dev;

   localparam logic [31:0] A_CTRL = 32'h0000_7F00;
   localparam logic [31:0] A_PRE  = 32'h0000_7F04;
   localparam logic [31:0] A_CNT  = 32'h0000_7F08;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] m_data_addr = 32'd0;
   logic [31:0] m_data_wdata = 32'd0;
   logic [3:0]  m_data_byteen = 4'd0;
   logic [31:0] m_data_rdata;
   logic        interrupt;

   int errors = 0;
   int checks = 0;
   logic [31:0] rv;

   timer_dev dut (
      .clk           (clk),
      .reset         (reset),
      .m_data_addr   (m_data_addr),
      .m_data_wdata  (m_data_wdata),
      .m_data_byteen (m_data_byteen),
      .m_data_rdata  (m_data_rdata),
      .interrupt     (interrupt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be);
      @(negedge clk);
      m_data_addr   = a;
      m_data_wdata  = d;
      m_data_byteen = be;
      @(posedge clk);
      #1;
      m_data_byteen = 4'd0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      m_data_addr = a;
      #1;
      d = m_data_rdata;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      // reset state
      #2;
      rd(A_CTRL, rv); chk("rst_ctrl", rv, 32'd0);
      rd(A_PRE, rv);  chk("rst_pre", rv, 32'd0);
      rd(A_CNT, rv);  chk("rst_cnt", rv, 32'd0);
      chk("rst_irq", {31'd0, interrupt}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // one-shot
      wr(A_PRE, 32'd5, 4'hF);
      wr(A_CTRL, 32'h9, 4'hF);
      tick(6);
      chk("os_e6", {31'd0, interrupt}, 32'd0);
      tick(1);
      chk("os_e7", {31'd0, interrupt}, 32'd1);
      tick(2);
      rd(A_CTRL, rv); chk("os_en_clr", rv, 32'h8);
      chk("os_hold", {31'd0, interrupt}, 32'd1);
      wr(A_CTRL, 32'h0, 4'hF);
      chk("os_clr", {31'd0, interrupt}, 32'd0);

      // periodic
      do_reset();
      wr(A_PRE, 32'd3, 4'hF);
      wr(A_CTRL, 32'hB, 4'hF);
      for (int e = 1; e <= 21; e++) begin
         tick(1);
         chk($sformatf("per_e%0d", e), {31'd0, interrupt},
             (e % 5 == 0) ? 32'd1 : 32'd0);
      end

      // masking
      do_reset();
      wr(A_PRE, 32'd5, 4'hF);
      wr(A_CTRL, 32'h1, 4'hF);
      tick(7);
      chk("msk_e7", {31'd0, interrupt}, 32'd0);
      rd(A_CNT, rv); chk("msk_cnt", rv, 32'd0);
      wr(A_CTRL, 32'h8, 4'hF);
      chk("msk_im", {31'd0, interrupt}, 32'd0);
      tick(2);
      chk("msk_im2", {31'd0, interrupt}, 32'd0);

      // byte writes, read-only COUNT, decode
      do_reset();
      wr(A_PRE, 32'h1122_3344, 4'hF);
      wr(A_PRE, 32'hAABB_CCDD, 4'b0010);
      rd(A_PRE, rv); chk("byte_pre", rv, 32'h1122_CC44);
      rd(A_PRE + 32'd3, rv); chk("lowbits", rv, 32'h1122_CC44);
      wr(A_CNT, 32'hDEAD_BEEF, 4'hF);
      rd(A_CNT, rv); chk("cnt_ro", rv, 32'd0);
      rd(32'h0000_7F0C, rv); chk("unmapped", rv, 32'd0);
      wr(A_CTRL, 32'hFFFF_FFF0, 4'hF);
      rd(A_CTRL, rv); chk("ctrl_hi0", rv, 32'd0);

      // reset mid-count
      do_reset();
      wr(A_PRE, 32'd100, 4'hF);
      wr(A_CTRL, 32'h9, 4'hF);
      tick(52);
      rd(A_CNT, rv); chk("mid_cnt50", rv, 32'd50);
      reset = 1'b1;
      #1;
      rd(A_CTRL, rv); chk("mid_ctrl", rv, 32'd0);
      rd(A_PRE, rv);  chk("mid_pre", rv, 32'd0);
      rd(A_CNT, rv);  chk("mid_cnt", rv, 32'd0);
      chk("mid_irq", {31'd0, interrupt}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick(5);
      rd(A_CNT, rv); chk("post_cnt", rv, 32'd0);
      chk("post_irq", {31'd0, interrupt}, 32'd0);

      // PRESET = 0 behaves as 1
      do_reset();
      wr(A_CTRL, 32'h9, 4'hF);
      tick(2);
      chk("p0_e2", {31'd0, interrupt}, 32'd0);
      tick(1);
      chk("p0_e3", {31'd0, interrupt}, 32'd1);

      // PRESET write at the edge that would fire
      do_reset();
      wr(A_PRE, 32'd4, 4'hF);
      wr(A_CTRL, 32'h9, 4'hF);
      tick(5);
      rd(A_CNT, rv); chk("se_cnt1", rv, 32'd1);
      wr(A_PRE, 32'd2, 4'hF);
      chk("se_e6_irq", {31'd0, interrupt}, 32'd0);
      rd(A_CNT, rv); chk("se_e6_cnt", rv, 32'd1);
      tick(1);
      chk("se_e7_irq", {31'd0, interrupt}, 32'd0);
      rd(A_CNT, rv); chk("se_e7_cnt", rv, 32'd1);
      tick(1);
      rd(A_CNT, rv); chk("se_e8_cnt", rv, 32'd2);
      tick(1);
      chk("se_e9_irq", {31'd0, interrupt}, 32'd0);
      tick(1);
      chk("se_e10_irq", {31'd0, interrupt}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_7F00, meaning the byte address of the first register (CTRL); PRESET is at BASE_ADDR+4 and COUNT at BASE_ADDR+8.
REQ-002 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port m_data_addr  input  32  CPU data byte address.
REQ-005 SHALL have port m_data_wdata  input  32  CPU write data.
REQ-006 SHALL have port m_data_byteen  input  4  per-byte write enables; nonzero means a write.
REQ-007 SHALL have port m_data_rdata  output  32  read data for the addressed register.
REQ-008 SHALL have port interrupt  output  1  interrupt request to the CPU.

Function
REQ-009 SHALL provide three registers: CTRL[3:0] (bit0 EN, bits2:1 MODE, bit3 IM) with bits 31:4 reading 0; PRESET[31:0]; and COUNT[31:0], which is read-only.
REQ-010 SHALL decode a register only when m_data_addr[31:2] equals that register's word address; bits 1:0 are ignored.
REQ-011 SHALL drive m_data_rdata combinationally from the addressed register, and SHALL drive 0 for any non-matching address.
REQ-012 SHALL apply a write at the rising edge, updating only the bytes whose m_data_byteen bit is set; writes to COUNT or to a non-matching address SHALL have no effect.
REQ-013 SHALL implement the FSM states IDLE, LOAD, CNT and INT.
REQ-014 In IDLE, the block SHALL move to LOAD on the next edge when EN=1, and SHALL otherwise stay in IDLE.
REQ-015 In LOAD, the block SHALL set COUNT <= PRESET and move to CNT.
REQ-016 In CNT with EN=0, the block SHALL move to IDLE and hold COUNT.
REQ-017 In CNT with EN=1 and COUNT>1, the block SHALL decrement COUNT by 1.
REQ-018 In CNT with EN=1 and COUNT<=1, the block SHALL set COUNT <= 0, set irq_pend, and move to INT.
REQ-019 PRESET=0 SHALL behave as PRESET=1, giving one CNT cycle.
REQ-020 In INT with MODE=00 (one-shot), the block SHALL clear EN and move to IDLE; irq_pend SHALL stay set until a CTRL write.
REQ-021 In INT with MODE=01 (periodic), the block SHALL clear irq_pend and move to LOAD, making irq_pend a one-cycle pulse per period.
REQ-022 MODE values 1x SHALL behave as MODE=00.
REQ-023 interrupt SHALL equal irq_pend AND IM, combinationally from registers, with no extra latency.
REQ-024 If a CTRL write (any byteen bit) and an FSM update occur at the same edge, the write SHALL win for CTRL; irq_pend SHALL be cleared, and the FSM SHALL go to IDLE regardless of its current state.
REQ-025 If a PRESET write and an FSM update occur at the same edge, the FSM SHALL go to IDLE; COUNT SHALL keep its value, and the count restarts from the new PRESET.
REQ-026 For cycle-level counting, with PRESET=N (N>=1) and EN written at edge 0, the block SHALL enter LOAD at edge 1, have COUNT=N at edge 2, and have irq_pend=1 at edge N+2.

Reset
REQ-027 While reset=1, the block SHALL immediately force state=IDLE, CTRL=0, PRESET=0, COUNT=0, irq_pend=0, and interrupt=0.
REQ-028 Reset asserted mid-count SHALL abandon the count with no interrupt; after release, the block SHALL stay in IDLE until EN is written.
REQ-029 Release of reset SHALL need no synchronisation inside this block.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the register word offsets (0, 1, 2), the CTRL bit positions and the MODE encodings.
REQ-031 One sub-module, tc_regfile, SHALL be used for address decode, byte-enable merge and read mux; the FSM and COUNT SHALL stay in timer_dev.
REQ-032 The block SHALL contain no combinational loops, and m_data_rdata SHALL not depend on m_data_wdata.

Verification
REQ-033 The bench SHALL cover one-shot: PRESET=5, then CTRL=4'b1001 -> interrupt rises 7 edges after the CTRL write, EN reads 0, and interrupt holds until a CTRL=0 write clears it the next edge.
REQ-034 The bench SHALL cover periodic: PRESET=3, CTRL=4'b1011 -> a one-cycle interrupt pulse every 5 cycles, repeated across at least 4 periods.
REQ-035 The bench SHALL cover masking: one-shot with IM=0 -> interrupt stays 0, while irq_pend is set (a later CTRL write with IM=1 clears it, so interrupt stays 0).
REQ-036 The bench SHALL cover byte writes: PRESET=32'h11223344, then byteen=4'b0010 with wdata=32'hAABBCCDD -> PRESET reads 32'h1122CC44; a COUNT write -> COUNT unchanged.
REQ-037 The bench SHALL cover reset mid-count: PRESET=100, EN=1, assert reset at COUNT=50 -> all registers read 0 and interrupt is 0 during reset and after release.
REQ-038 The bench SHALL cover the PRESET=0 and same-edge cases: PRESET=0 with EN -> irq_pend at edge 3; a PRESET write at the same edge COUNT reaches 1 -> no interrupt, and the FSM is in IDLE, then restarts.
